// File: rtl/multi_edge_detect_if.sv
// rtl/multi_edge_detect_if.sv - level inputs, edge modes and event outputs of the multi-channel edge detector
interface multi_edge_detect_if #(
    parameter int CHANNELS = 4
) ();
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0]   level_in;
    logic [2*CHANNELS-1:0] mode;
    logic [CHANNELS-1:0]   clear;
    logic [CHANNELS-1:0]   pulse_out;
    logic [CHANNELS-1:0]   stable_out;
    logic [CHANNELS-1:0]   sticky_out;
    logic                  any_pulse;
    logic [IDX_W-1:0]      first_idx;

    modport master (
        output level_in, mode, clear,
        input  pulse_out, stable_out, sticky_out, any_pulse, first_idx
    );

    modport slave (
        input  level_in, mode, clear,
        output pulse_out, stable_out, sticky_out, any_pulse, first_idx
    );
endinterface

// File: rtl/multi_edge_detect.sv
// rtl/multi_edge_detect.sv - per-channel synchroniser, debouncer, edge pulse and sticky flag
module multi_edge_detect #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               n_reset,
    multi_edge_detect_if.slave bus
);
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    logic [CNT_W-1:0]       cnt_q  [CHANNELS];
    logic [CHANNELS-1:0]    stable_q;
    logic [CHANNELS-1:0]    pulse_q;
    logic [CHANNELS-1:0]    sticky_q;

    logic [CHANNELS-1:0]    s;
    logic [CHANNELS-1:0]    toggle;
    logic [CHANNELS-1:0]    qualified;
    logic [IDX_W-1:0]       first;

    // A toggle is accepted on the edge where the mismatch has already lasted DEBOUNCE_CYCLES-1 clocks.
    always_comb begin
        s         = '0;
        toggle    = '0;
        qualified = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            s[i]         = sync_q[i][SYNC_STAGES-1];
            toggle[i]    = (s[i] != stable_q[i]) && (cnt_q[i] == CNT_LAST);
            qualified[i] = toggle[i] && (s[i] ? bus.mode[2*i] : bus.mode[2*i+1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            stable_q <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.level_in[i]};
                if (s[i] == stable_q[i] || toggle[i]) begin
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
            stable_q <= stable_q ^ toggle;
            pulse_q  <= qualified;
            // Set has priority over clear so an event arriving with a clear is never lost.
            sticky_q <= qualified | (sticky_q & ~bus.clear);
        end
    end

    always_comb begin
        first = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pulse_q[i]) begin
                first = IDX_W'(i);
            end
        end
    end

    assign bus.pulse_out  = pulse_q;
    assign bus.stable_out = stable_q;
    assign bus.sticky_out = sticky_q;
    assign bus.any_pulse  = |pulse_q;
    assign bus.first_idx  = first;
endmodule
